// File: rtl/chip8_vga_scan.sv
// chip8_vga_scan
// 640x480@60 VGA scan generator for a 64x32 monochrome CHIP-8 framebuffer.
// The image is upscaled by SCALE in both directions, left-aligned and placed
// vertically starting at line V_OFFSET. A snapshot of the CPU framebuffer is
// taken once per frame at the start of vertical blanking, so the CPU may
// rewrite the framebuffer at any time without tearing the displayed frame.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   display      CPU framebuffer, bit y*64+x is pixel (x,y), bit 0 top-left
//   pix_en       pixel-clock enable, one pulse per screen pixel
//   hsync        horizontal sync, active level SYNC_POL
//   vsync        vertical sync, active level SYNC_POL
//   video_on     high inside the 640x480 visible area
//   pixel        monochrome pixel value, 0 outside the upscaled image
//   frame_start  one-clk pulse on the edge that captures the snapshot
module chip8_vga_scan #(
  parameter int SCALE    = 10,
  parameter int V_OFFSET = 80,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2047:0] display,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          pixel,
  output logic          frame_start
);

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd751;
  localparam logic [9:0] H_MAX    = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd491;
  localparam logic [9:0] V_MAX    = 10'd524;

  localparam logic [9:0] IMG_W  = 10'(64 * SCALE);
  localparam logic [9:0] IMG_Y0 = 10'(V_OFFSET);
  localparam logic [9:0] IMG_Y1 = 10'(V_OFFSET + 32 * SCALE);

  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'(SCALE - 1);

  logic [9:0]    hcount_q, hcount_d;
  logic [9:0]    vcount_q, vcount_d;
  logic [SW-1:0] xsub_q, xsub_d;
  logic [SW-1:0] ysub_q, ysub_d;
  logic [5:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [2047:0] snap_q;

  logic hsync_q, vsync_q, video_on_q, pixel_q, frame_start_q;

  logic h_end, v_end, in_img, capture;

  assign h_end   = (hcount_q == H_MAX);
  assign v_end   = (vcount_q == V_MAX);
  assign in_img  = (hcount_q < IMG_W) && (vcount_q >= IMG_Y0) && (vcount_q < IMG_Y1);
  assign capture = (hcount_q == 10'd0) && (vcount_q == V_VIS);

  // Counter advance. col/row are the CHIP-8 coordinates, xsub/ysub count the
  // screen pixels within one CHIP-8 pixel; they replace hcount/SCALE and
  // (vcount-V_OFFSET)/SCALE. Values beyond the image region are never used.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    xsub_d   = xsub_q;
    ysub_d   = ysub_q;
    col_d    = col_q;
    row_d    = row_q;
    if (pix_en) begin
      if (h_end) begin
        hcount_d = 10'd0;
        xsub_d   = '0;
        col_d    = 6'd0;
        if (v_end) begin
          vcount_d = 10'd0;
          ysub_d   = '0;
          row_d    = 5'd0;
        end else begin
          vcount_d = vcount_q + 10'd1;
          // Rows start counting only once the first image line has been shown.
          if (vcount_q >= IMG_Y0) begin
            if (ysub_q == SUB_MAX) begin
              ysub_d = '0;
              row_d  = row_q + 5'd1;
            end else begin
              ysub_d = ysub_q + SW'(1);
            end
          end
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
        if (xsub_q == SUB_MAX) begin
          xsub_d = '0;
          col_d  = col_q + 6'd1;
        end else begin
          xsub_d = xsub_q + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      xsub_q        <= '0;
      ysub_q        <= '0;
      col_q         <= 6'd0;
      row_q         <= 5'd0;
      snap_q        <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pixel_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      xsub_q        <= xsub_d;
      ysub_q        <= ysub_d;
      col_q         <= col_d;
      row_q         <= row_d;
      if (pix_en) begin
        // Outputs decode the counters as they were before this advance.
        hsync_q    <= ((hcount_q >= H_SYNC_S) && (hcount_q <= H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
        vsync_q    <= ((vcount_q >= V_SYNC_S) && (vcount_q <= V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
        video_on_q <= (hcount_q < H_VIS) && (vcount_q < V_VIS);
        pixel_q    <= in_img ? snap_q[{row_q, col_q}] : 1'b0;
        if (capture) begin
          snap_q        <= display;
          frame_start_q <= 1'b1;
        end
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel       = pixel_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/chip8_vga_scan.md
CHIP8_VGA_SCAN -- requirements
Module: chip8_vga_scan

Interface
REQ-001 SHALL have parameter SCALE, default 10: screen pixels per CHIP-8 pixel, horizontal and vertical.
REQ-002 SHALL have parameter V_OFFSET, default 80: first visible line of the 64x32 image (centres 320 image lines in 480).
REQ-003 SHALL have parameter SYNC_POL, default 0: active level of hsync/vsync.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port display, input, 2048: CPU framebuffer; bit y*64+x is pixel (x,y); bit 0 is top-left.
REQ-007 SHALL have port pix_en, input, 1: pixel-clock enable, one pulse per screen pixel.
REQ-008 SHALL have port hsync, output, 1: horizontal sync.
REQ-009 SHALL have port vsync, output, 1: vertical sync.
REQ-010 SHALL have port video_on, output, 1: high inside the 640x480 visible area.
REQ-011 SHALL have port pixel, output, 1: monochrome pixel value.
REQ-012 SHALL have port frame_start, output, 1: one-clk pulse when a new framebuffer snapshot is taken.

Function
REQ-013 SHALL keep hcount 0..799 and vcount 0..524; both advance only on clk edges with pix_en=1.
REQ-014 hcount SHALL wrap 799->0 and increment vcount; vcount SHALL wrap 524->0 at hcount 799.
REQ-015 Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 Outputs SHALL be registered: on a pix_en edge they take values decoded from the pre-increment counters. Latency is 1 clk, all four outputs aligned.
REQ-018 hsync SHALL equal SYNC_POL while hcount is 656..751, else ~SYNC_POL; vsync likewise for vcount 490..491.
REQ-019 video_on SHALL be 1 iff hcount<640 and vcount<480.
REQ-020 Image region: hcount<64*SCALE and V_OFFSET<=vcount<V_OFFSET+32*SCALE.
REQ-021 pixel SHALL be snap[row*64+col] inside the image region and 0 elsewhere, including border and blanking.
REQ-022 col=hcount/SCALE and row=(vcount-V_OFFSET)/SCALE SHALL use sub-counters (xsub/col, ysub/row), no dividers.
REQ-023 snap SHALL be a 2048-bit register loaded from display on the pix_en edge where hcount=0 and vcount=480.
REQ-024 frame_start SHALL pulse high for exactly one clk on that same edge, else 0.
REQ-025 display changes outside the capture edge SHALL NOT affect pixel until the next capture; no tearing.
REQ-026 With pix_en=0, all counters, snap and outputs SHALL hold, except frame_start, which returns to 0.

Reset
REQ-027 reset=1 at a clk edge SHALL force: counters and sub-counters to 0, snap=0, hsync=vsync=~SYNC_POL, video_on=0, pixel=0, frame_start=0.
REQ-028 reset SHALL override pix_en; reset mid-frame restarts at hcount=vcount=0 on the next pix_en after release.
REQ-029 The first frame after reset SHALL display blank (snap=0) until the first capture at vcount=480.

Verification
REQ-030 Reset, pix_en=1 continuously, 800*525 edges -> hsync=0 for 96 clks per line starting 1 clk after hcount=656; vsync=0 for 1600 clks; video_on high 640x480 clks.
REQ-031 display bit0=1, wait for frame_start -> in the next frame pixel=1 only for hcount 0..9, vcount 80..89.
REQ-032 display bit2047=1, after capture -> pixel=1 only for hcount 630..639, vcount 390..399; pixel=0 on lines 0..79 and 400..479.
REQ-033 display toggled to all-ones at vcount=200, then back to 0 before vcount=480 -> current frame unchanged; frame_start fires once per 420000 pix_en edges.
REQ-034 pix_en=1 every 4th clk, gap of 100 clks at hcount=300 -> outputs frozen during the gap; timing correct in pix_en units.
REQ-035 reset asserted at vcount=250 for 3 clks -> outputs return to reset values; next frame blank; hcount/vcount restart from 0.
